// File: rtl/parametric_locker_controller.sv
// Multi-locker delivery controller: courier deposits into the lowest free locker,
// recipients retrieve with their stored PIN, with timed door pulses and fail lockout.
module parametric_locker_controller #(
    parameter int unsigned          NUM_LOCKERS      = 8,
    parameter int unsigned          IDX_W            = 3,
    parameter int unsigned          PIN_W            = 4,
    parameter logic [PIN_W-1:0]     COURIER_PIN      = 4'b1010,
    parameter int unsigned          MAX_FAILS        = 3,
    parameter int unsigned          LOCKOUT_CYCLES   = 16,
    parameter int unsigned          DOOR_OPEN_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dep_req,
    input  logic [PIN_W-1:0]       dep_pin,
    input  logic [PIN_W-1:0]       recip_pin,
    input  logic                   ret_req,
    input  logic [PIN_W-1:0]       ret_pin,
    input  logic                   clear_all,
    output logic                   auth_success_led,
    output logic                   retrieval_auth_led,
    output logic                   err,
    output logic [IDX_W-1:0]       assigned_locker_display,
    output logic [NUM_LOCKERS-1:0] locker_doors,
    output logic [NUM_LOCKERS-1:0] occupied,
    output logic                   full,
    output logic                   busy,
    output logic                   lockout
);

    localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > DOOR_OPEN_CYCLES) ? LOCKOUT_CYCLES : DOOR_OPEN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(MAX_FAILS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOOR_OPEN = 2'd1,
        LOCKOUT   = 2'd2
    } state_t;

    state_t                                r_state,  w_state_n;
    logic [NUM_LOCKERS-1:0]                r_occ,    w_occ_n;
    logic [NUM_LOCKERS-1:0][PIN_W-1:0]     r_pin,    w_pin_n;
    logic [NUM_LOCKERS-1:0]                r_doors,  w_doors_n;
    logic [IDX_W-1:0]                      r_disp,   w_disp_n;
    logic [CNT_W-1:0]                      r_fail,   w_fail_n;
    logic [TMR_W-1:0]                      r_tmr,    w_tmr_n;
    logic                                  r_dep_ok, w_dep_ok_n;
    logic                                  r_ret_ok, w_ret_ok_n;
    logic                                  r_err,    w_err_n;
    logic                                  r_busy,   r_lockout;
    logic                                  w_fail_inc;
    logic [CNT_W:0]                        w_fail_p1;
    logic                                  w_free_hit, w_match_hit;
    logic [IDX_W-1:0]                      w_free_idx, w_match_idx;

    // Priority search: lowest free locker and lowest occupied locker whose PIN matches
    always_comb begin
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_match_hit = 1'b0;
        w_match_idx = '0;
        for (int i = int'(NUM_LOCKERS) - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_occ[i] && (r_pin[i] == ret_pin)) begin
                w_match_hit = 1'b1;
                w_match_idx = IDX_W'(i);
            end
        end
    end

    assign w_fail_p1 = (CNT_W + 1)'(r_fail) + (CNT_W + 1)'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state_n  = r_state;
        w_occ_n    = r_occ;
        w_pin_n    = r_pin;
        w_doors_n  = r_doors;
        w_disp_n   = r_disp;
        w_fail_n   = r_fail;
        w_tmr_n    = r_tmr;
        w_dep_ok_n = 1'b0;
        w_ret_ok_n = 1'b0;
        w_err_n    = 1'b0;
        w_fail_inc = 1'b0;

        case (r_state)
            IDLE: begin
                if (dep_req) begin
                    if (dep_pin != COURIER_PIN) begin
                        w_err_n    = 1'b1;
                        w_fail_inc = 1'b1;
                    end else if (!w_free_hit) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_occ_n[w_free_idx] = 1'b1;
                        w_pin_n[w_free_idx] = recip_pin;
                        w_doors_n           = NUM_LOCKERS'(1) << w_free_idx;
                        w_disp_n            = w_free_idx;
                        w_dep_ok_n          = 1'b1;
                        w_fail_n            = '0;
                        w_tmr_n             = TMR_W'(DOOR_OPEN_CYCLES);
                        w_state_n           = DOOR_OPEN;
                    end
                end else if (ret_req) begin
                    if (w_match_hit) begin
                        w_occ_n[w_match_idx] = 1'b0;
                        w_pin_n[w_match_idx] = '0;
                        w_doors_n            = NUM_LOCKERS'(1) << w_match_idx;
                        w_disp_n             = w_match_idx;
                        w_ret_ok_n           = 1'b1;
                        w_fail_n             = '0;
                        w_tmr_n              = TMR_W'(DOOR_OPEN_CYCLES);
                        w_state_n            = DOOR_OPEN;
                    end else begin
                        w_err_n    = 1'b1;
                        w_fail_inc = 1'b1;
                    end
                end
                if (w_fail_inc) begin
                    if (w_fail_p1 >= (CNT_W + 1)'(MAX_FAILS)) begin
                        w_fail_n  = '0;
                        w_tmr_n   = TMR_W'(LOCKOUT_CYCLES);
                        w_state_n = LOCKOUT;
                    end else begin
                        w_fail_n = CNT_W'(w_fail_p1);
                    end
                end
            end
            DOOR_OPEN, LOCKOUT: begin
                if (r_tmr <= TMR_W'(1)) begin
                    w_tmr_n   = '0;
                    w_doors_n = '0;
                    w_state_n = IDLE;
                end else begin
                    w_tmr_n = r_tmr - TMR_W'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_doors_n = '0;
                w_tmr_n   = '0;
            end
        endcase

        // Administrative clear overrides everything except the display
        if (clear_all) begin
            w_state_n  = IDLE;
            w_occ_n    = '0;
            w_pin_n    = '0;
            w_doors_n  = '0;
            w_fail_n   = '0;
            w_tmr_n    = '0;
            w_dep_ok_n = 1'b0;
            w_ret_ok_n = 1'b0;
            w_err_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_occ     <= '0;
            r_pin     <= '0;
            r_doors   <= '0;
            r_disp    <= '0;
            r_fail    <= '0;
            r_tmr     <= '0;
            r_dep_ok  <= 1'b0;
            r_ret_ok  <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_lockout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_occ     <= w_occ_n;
            r_pin     <= w_pin_n;
            r_doors   <= w_doors_n;
            r_disp    <= w_disp_n;
            r_fail    <= w_fail_n;
            r_tmr     <= w_tmr_n;
            r_dep_ok  <= w_dep_ok_n;
            r_ret_ok  <= w_ret_ok_n;
            r_err     <= w_err_n;
            r_busy    <= (w_state_n != IDLE);
            r_lockout <= (w_state_n == LOCKOUT);
        end
    end

    assign auth_success_led        = r_dep_ok;
    assign retrieval_auth_led      = r_ret_ok;
    assign err                     = r_err;
    assign assigned_locker_display = r_disp;
    assign locker_doors            = r_doors;
    assign occupied                = r_occ;
    assign full                    = &r_occ;
    assign busy                    = r_busy;
    assign lockout                 = r_lockout;

endmodule

// File: doc/parametric_locker_controller.md
Name: parametric_locker_controller

Overview:
Parametrised successor to the single-locker delivery controller. It manages NUM_LOCKERS lockers, each with its own stored recipient PIN. Couriers deposit with a shared courier PIN and get the lowest free locker. Recipients retrieve with their own PIN. Doors pulse open for a timed window, and repeated wrong PINs trigger a timed lockout. The block sits between the keypad front-end and the door solenoid drivers.

Parameters:
NUM_LOCKERS, 8, number of lockers (2..64)
IDX_W, 3, locker index width, equals $clog2(NUM_LOCKERS)
PIN_W, 4, PIN width in bits
COURIER_PIN, 4'b1010, courier authentication PIN (PIN_W bits)
MAX_FAILS, 3, consecutive failed attempts that trigger lockout
LOCKOUT_CYCLES, 16, lockout duration in clk cycles
DOOR_OPEN_CYCLES, 8, door-open pulse duration in clk cycles

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dep_req  in  1  deposit request, sampled when high for one cycle
dep_pin  in  PIN_W  courier PIN, valid with dep_req
recip_pin  in  PIN_W  recipient PIN to store, valid with dep_req
ret_req  in  1  retrieval request, sampled when high for one cycle
ret_pin  in  PIN_W  recipient PIN, valid with ret_req
clear_all  in  1  synchronous administrative clear of all lockers
auth_success_led  out  1  one-cycle pulse on accepted deposit
retrieval_auth_led  out  1  one-cycle pulse on accepted retrieval
err  out  1  one-cycle pulse on any rejected request
assigned_locker_display  out  IDX_W  index of the last opened locker
locker_doors  out  NUM_LOCKERS  one-hot door-open drive
occupied  out  NUM_LOCKERS  per-locker occupancy
full  out  1  all lockers occupied (combinational from occupied)
busy  out  1  high in any state other than IDLE
lockout  out  1  high in LOCKOUT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs, occupied, stored PINs, fail counter and timers are 0.
  - assigned_locker_display=0.
- All outputs are registered. A request sampled at edge k produces its response after edge k, visible during cycle k+1.
- State machine: IDLE, DOOR_OPEN, LOCKOUT.
- IDLE:
  - If dep_req and ret_req are both high, the deposit is served and the retrieval is dropped without an err pulse.
  - Deposit accept: dep_req=1, dep_pin==COURIER_PIN, !full.
    - Select the lowest-index free locker i.
    - Store recip_pin[i], set occupied[i]=1.
    - Set locker_doors to one-hot i and assigned_locker_display=i.
    - Pulse auth_success_led; clear the fail counter; go to DOOR_OPEN.
  - Deposit while full (correct PIN): err pulse, fail counter unchanged, stay in IDLE.
  - Deposit with wrong dep_pin: err pulse, fail counter +1.
  - Retrieval accept: ret_req=1 and the lowest-index occupied locker j has stored PIN == ret_pin.
    - Clear occupied[j] and the stored PIN.
    - Set locker_doors to one-hot j and assigned_locker_display=j.
    - Pulse retrieval_auth_led; clear the fail counter; go to DOOR_OPEN.
  - Retrieval with no match (including when no locker is occupied): err pulse, fail counter +1.
  - When the fail counter reaches MAX_FAILS: go to LOCKOUT, clear the counter, load the LOCKOUT_CYCLES timer.
- DOOR_OPEN:
  - locker_doors is held for exactly DOOR_OPEN_CYCLES cycles, then returns to 0 and the state returns to IDLE on the same edge.
  - dep_req and ret_req are ignored: no err pulse, no counter change.
- LOCKOUT:
  - lockout=1; all requests are ignored.
  - Leave for IDLE after exactly LOCKOUT_CYCLES cycles.
- clear_all: synchronous, highest priority in every state. On the next edge:
  - occupied=0, stored PINs=0, locker_doors=0, fail counter=0, timers=0, state=IDLE.
  - assigned_locker_display is unchanged.
- Fail counter saturates at MAX_FAILS and is never observable above it.
- Duplicate recipient PINs are legal; retrieval always opens the lowest matching index first.
- At most one door bit is ever set.
- Asynchronous reset asserted mid-DOOR_OPEN or mid-LOCKOUT forces all reset values immediately, without waiting for a clock edge.

Test Plan:
1. Release reset; pulse dep_req with dep_pin=1010, recip_pin=0011.
   - Next cycle: auth_success_led=1 for 1 cycle, assigned_locker_display=0, locker_doors=00000001, occupied=00000001.
   - locker_doors returns to 0 after 8 cycles, busy returns to 0.
2. Perform 8 valid deposits; full=1 and occupied=11111111.
   - A 9th deposit with dep_pin=1010 gives an err pulse, locker_doors stays 0, and lockout never asserts.
3. With locker 0 holding PIN 0011, pulse ret_req with ret_pin=0011.
   - Expect a retrieval_auth_led pulse, locker_doors=00000001, occupied bit 0 cleared.
   - The next valid deposit reuses index 0.
4. Issue three retrievals with ret_pin=1111 and no match.
   - Expect 3 err pulses, then lockout=1 for exactly 16 cycles, with dep_req ignored during that time.
   - After lockout, ret_pin=0011 succeeds.
5. Assert dep_req and ret_req in the same cycle (valid PINs for both): only the deposit is served and no err pulse occurs.
   - Pulse dep_req during DOOR_OPEN: ignored, no err pulse.
6. Assert clear_all during DOOR_OPEN: next cycle locker_doors=0, occupied=0, busy=0.
   - Drive reset low mid-LOCKOUT: outputs go to 0 immediately, without a clock edge.
